// File: rtl/tb_sender_receiver.sv
// Purpose: sequence traffic generator (4-bit counter with LFSR-varied idle gaps) plus an independent in-order checker.
// Latency: first strobe one edge after reset release; failure/expected update one cycle after an rx_en sample.
// Backpressure: none -- the sender free-runs and the receiver accepts every rx_en beat.
module tb_sender_receiver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] gap_from,
  input  logic [7:0] gap_to,
  output logic [3:0] data,
  output logic       en,
  input  logic       rx_en,
  input  logic [3:0] rx_data,
  output logic [3:0] expected,
  output logic       failure
);

  // Sender state
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] gap_q, gap_d;
  logic [3:0] next_q, next_d;
  logic [3:0] data_q, data_d;
  logic       en_q, en_d;

  // Receiver state
  logic [3:0] expected_q, expected_d;
  logic       failure_q, failure_d;

  // Gap computation scratch
  logic [8:0] span;
  logic [8:0] rem;
  logic [7:0] gap_len;

  // Next gap length: fixed when bounds are inverted or equal, otherwise offset by LFSR modulo the span.
  always_comb begin
    span    = {1'b0, gap_to} - {1'b0, gap_from} + 9'd1;
    rem     = 9'd0;
    gap_len = gap_from;
    if (gap_to > gap_from) begin
      // span >= 2 here, so the modulo never divides by zero
      rem     = {1'b0, lfsr_q} % span;
      gap_len = 8'({1'b0, gap_from} + rem);
    end
  end

  // Sender next-state: LFSR free-runs; a strobe fires whenever the gap counter has drained.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    gap_d  = gap_q;
    next_d = next_q;
    data_d = data_q;
    en_d   = 1'b0;
    if (gap_q != 8'd0) begin
      gap_d = gap_q - 8'd1;
    end else begin
      en_d   = 1'b1;
      data_d = next_q;
      next_d = next_q + 4'd1;
      gap_d  = gap_len;
    end
  end

  // Receiver next-state: flag an out-of-order value, then resynchronise to whatever arrived.
  always_comb begin
    expected_d = expected_q;
    failure_d  = 1'b0;
    if (rx_en) begin
      failure_d  = (rx_data != expected_q);
      expected_d = rx_data + 4'd1;
    end
  end

  // Sender registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'h01;
      gap_q  <= 8'd0;
      next_q <= 4'd0;
      data_q <= 4'd0;
      en_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      gap_q  <= gap_d;
      next_q <= next_d;
      data_q <= data_d;
      en_q   <= en_d;
    end
  end

  // Receiver registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_q <= 4'd0;
      failure_q  <= 1'b0;
    end else begin
      expected_q <= expected_d;
      failure_q  <= failure_d;
    end
  end

  assign data     = data_q;
  assign en       = en_q;
  assign expected = expected_q;
  assign failure  = failure_q;

endmodule

// File: tb/tb_tb_sender_receiver.sv
// Bench for tb_sender_receiver: loopback with optional single-bit corruption, checked
// cycle by cycle against a strobe-schedule reference model.
module tb_tb_sender_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gap_from, gap_to;
  logic [3:0] data;
  logic       en;
  logic       rx_en;
  logic [3:0] rx_data;
  logic [3:0] expected;
  logic       failure;
  logic       corrupt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rx_en   = en;
  assign rx_data = data ^ {3'b000, corrupt};

  tb_sender_receiver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gap_from (gap_from),
    .gap_to   (gap_to),
    .data     (data),
    .en       (en),
    .rx_en    (rx_en),
    .rx_data  (rx_data),
    .expected (expected),
    .failure  (failure)
  );

  // Reference model: schedule of strobe cycles plus an in-order receiver.
  int         cyc;
  int         next_strobe;
  int         strobes;
  int         strobe_cyc [0:255];
  logic [7:0] m_lfsr;
  logic [3:0] m_next, m_data, m_exp;
  logic       m_en, m_fail;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    // x^8 + x^6 + x^5 + x^4 + 1
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int gap_of(input int lf, input int lo, input int hi);
    if (hi <= lo) return lo;
    return lo + (lf % (hi - lo + 1));
  endfunction

  task automatic model_reset();
    cyc = 0; next_strobe = 1; strobes = 0;
    m_lfsr = 8'h01; m_next = 4'd0; m_data = 4'd0; m_exp = 4'd0;
    m_en = 1'b0; m_fail = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    corrupt = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance one clock and update the model's view of that cycle.
  task automatic step();
    logic       pre_en;
    logic [3:0] pre_data;
    pre_en   = m_en;
    pre_data = m_data ^ {3'b000, corrupt};
    @(posedge clk);
    #1;
    cyc++;
    m_fail = pre_en && (pre_data != m_exp);
    if (pre_en) m_exp = pre_data + 4'd1;
    if (cyc == next_strobe) begin
      m_en = 1'b1;
      m_data = m_next;
      m_next = m_next + 4'd1;
      if (strobes < 256) strobe_cyc[strobes] = cyc;
      strobes++;
      next_strobe = cyc + gap_of(int'(m_lfsr), int'(gap_from), int'(gap_to)) + 1;
    end else begin
      m_en = 1'b0;
    end
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; corrupt = 1'b0; gap_from = 8'd0; gap_to = 8'd0;
    #1;
    tests++;
    if ({en, data, expected, failure} !== 10'd0) begin
      fails++;
      $display("FAIL reset_state got %b want %b", {en, data, expected, failure}, 10'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({en, data, expected, failure} !== 10'd0) begin
      fails++;
      $display("FAIL reset_held got %b want %b", {en, data, expected, failure}, 10'd0);
    end
  endtask

  task automatic test_fixed_gap();
    int last;
    gap_from = 8'd5; gap_to = 8'd5;
    do_reset();
    last = -1;
    for (int i = 0; i < 50; i++) begin
      step();
      tests++;
      if ({en, data, expected, failure} !== {m_en, m_data, m_exp, m_fail}) begin
        fails++;
        $display("FAIL fixed_gap cyc=%0d got %b want %b", cyc, {en, data, expected, failure}, {m_en, m_data, m_exp, m_fail});
      end
      if (en) begin
        if (last >= 0) begin
          tests++;
          if (cyc - last !== 6) begin
            fails++;
            $display("FAIL fixed_gap_spacing cyc=%0d got %0d want 6", cyc, cyc - last);
          end
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_back_to_back();
    gap_from = 8'd0; gap_to = 8'd0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      tests++;
      if ({en, data, failure} !== {1'b1, 4'(cyc - 1), 1'b0}) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d got en=%b data=%0d fail=%b want en=1 data=%0d fail=0", cyc, en, data, failure, 4'(cyc - 1));
      end
      tests++;
      if (expected !== m_exp) begin
        fails++;
        $display("FAIL back_to_back_expected cyc=%0d got %0d want %0d", cyc, expected, m_exp);
      end
    end
  endtask

  task automatic run_gap_bounds(input string name, input logic [7:0] lo, input logic [7:0] hi,
                                input int n, input int min_idle, input int max_idle);
    int last;
    gap_from = lo; gap_to = hi;
    do_reset();
    last = -1;
    for (int i = 0; i < n; i++) begin
      step();
      tests++;
      if ({en, data, expected, failure} !== {m_en, m_data, m_exp, m_fail}) begin
        fails++;
        $display("FAIL %s cyc=%0d got %b want %b", name, cyc, {en, data, expected, failure}, {m_en, m_data, m_exp, m_fail});
      end
      if (en) begin
        if (last >= 0) begin
          tests++;
          if ((cyc - last - 1) < min_idle || (cyc - last - 1) > max_idle) begin
            fails++;
            $display("FAIL %s_idle cyc=%0d got %0d want %0d..%0d", name, cyc, cyc - last - 1, min_idle, max_idle);
          end
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_random_gap();
    run_gap_bounds("random_gap", 8'd0, 8'd10, 200, 0, 10);
  endtask

  task automatic test_inverted_bounds();
    run_gap_bounds("inverted", 8'd7, 8'd3, 60, 7, 7);
  endtask

  task automatic test_gap_change();
    gap_from = 8'd3; gap_to = 8'd3;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      if (i == 17) begin gap_from = 8'd1; gap_to = 8'd4; end
      step();
      tests++;
      if ({en, data, expected, failure} !== {m_en, m_data, m_exp, m_fail}) begin
        fails++;
        $display("FAIL gap_change cyc=%0d got %b want %b", cyc, {en, data, expected, failure}, {m_en, m_data, m_exp, m_fail});
      end
    end
  endtask

  task automatic test_corruption();
    int pulses;
    int pulse_cyc [0:7];
    gap_from = 8'd2; gap_to = 8'd2;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      corrupt = m_en && (strobes == 4);
      tests++;
      if ({en, data, expected, failure} !== {m_en, m_data, m_exp, m_fail}) begin
        fails++;
        $display("FAIL corruption cyc=%0d got %b want %b", cyc, {en, data, expected, failure}, {m_en, m_data, m_exp, m_fail});
      end
      if (failure) begin
        if (pulses < 8) pulse_cyc[pulses] = cyc;
        pulses++;
      end
    end
    corrupt = 1'b0;
    tests++;
    if (pulses !== 2) begin
      fails++;
      $display("FAIL corruption_pulses got %0d want 2", pulses);
    end else begin
      tests++;
      if (pulse_cyc[0] !== strobe_cyc[3] + 1 || pulse_cyc[1] !== strobe_cyc[4] + 1) begin
        fails++;
        $display("FAIL corruption_timing got %0d,%0d want %0d,%0d", pulse_cyc[0], pulse_cyc[1], strobe_cyc[3] + 1, strobe_cyc[4] + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    gap_from = 8'd2; gap_to = 8'd2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      tests++;
      if ({en, data, expected, failure} !== {m_en, m_data, m_exp, m_fail}) begin
        fails++;
        $display("FAIL reset_mid_pre cyc=%0d got %b want %b", cyc, {en, data, expected, failure}, {m_en, m_data, m_exp, m_fail});
      end
      if (m_en && m_data == 4'd9) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reset_mid_reach got no data=9 want data=9 within 100 cycles");
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({en, data, expected, failure} !== 10'd0) begin
      fails++;
      $display("FAIL reset_mid_async got %b want %b", {en, data, expected, failure}, 10'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      tests++;
      if ({en, data, expected, failure} !== {m_en, m_data, m_exp, m_fail} || failure !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_post cyc=%0d got %b want %b", cyc, {en, data, expected, failure}, {m_en, m_data, m_exp, m_fail});
      end
      if (cyc == 1) begin
        tests++;
        if ({en, data} !== {1'b1, 4'd0}) begin
          fails++;
          $display("FAIL reset_mid_first got en=%b data=%0d want en=1 data=0", en, data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_gap();
    test_back_to_back();
    test_random_gap();
    test_inverted_bounds();
    test_gap_change();
    test_corruption();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
